round_robin_arbiter: RTL and testbench
======================================

# round_robin_arbiter

Registered, parametrised arbiter that grants one of `width` requesters exclusive ownership of a shared resource, such as the bus or memory port. Ownership is held while the owner keeps requesting. It is optionally preempted after a bounded hold time. Selection is either fixed-priority (lowest index wins) or round-robin (search starts one past the previous owner). The block sits between multiple bus masters and the shared-bus multiplexer, and its registered grant drives the mux select directly.

## Interface
- `width`, 4: number of requesters, ≥1.
- `roundRobin`, 1: 1 = rotating priority; 0 = fixed priority, lowest index wins.
- `maxHold`, 0: maximum owner tenure in cycles while others wait; 0 = unlimited.
- `holdWidth`, 8: width of the hold counter; must satisfy maxHold < 2^holdWidth.
- `indexWidth`, 2: width of `grantIndex`; must satisfy 2^indexWidth ≥ width.
- `clk`  input  1  system clock; all state changes on rising edge.
- `reset`  input  1  reset, synchronous to `clk`, active-high.
- `request`  input  width  request lines; requester i holds `request[i]` high for as long as it wants ownership.
- `grant`  output  width  registered one-hot (or zero) ownership vector.
- `grantValid`  output  1  registered; equals OR of `grant`.
- `grantIndex`  output  indexWidth  registered binary index of owner; 0 when `grantValid` = 0.

## Operation
- State:
  - owner-valid flag;
  - owner index;
  - priority pointer `ptr` (0..width-1);
  - hold counter.
- Two states:
  - IDLE: no owner.
  - OWNED: `grant[owner]` = 1.
- Arbitration happens at an edge (call it "arbitrate") when any of these holds:
  - state is IDLE;
  - `request[owner]` = 0 (release);
  - preemption: maxHold ≠ 0, hold counter = maxHold, and some other request is pending.
- Arbitration:
  - Candidate set = `request`, with the current owner masked out on preemption.
  - Winner = first set candidate found searching from `ptr` upward with wrap to 0.
  - fixed mode: search always starts at 0.
  - If the candidate set is empty: go to IDLE and clear `grant`.
  - Otherwise: OWNED with winner, `grant` = one-hot(winner), hold counter := 0.
- When the winner is taken (round-robin mode only): `ptr` := (winner+1) mod width. `ptr` is unchanged when no winner is found.
- No arbitration: keep owner; hold counter increments, saturating at maxHold.
- Hold counter only advances while OWNED.
- Preemption with no other requester pending: the owner keeps the grant and the counter stays saturated, so the owner is not dropped.
- Release and handover occur on the same edge: the new winner receives `grant` with zero idle cycles between owners.
- Requests arriving while another owner holds the grant are ignored until the next arbitrate edge. There is no queueing beyond the live `request` lines.
- width = 1: degenerates to `grant` = registered `request[0]`, with preemption never firing.

## Timing
- Reset, at an edge with `reset` = 1:
  - `grant` = 0, `grantValid` = 0, `grantIndex` = 0;
  - `ptr` = 0, hold counter = 0, state IDLE.
  - `request` is ignored at that edge.
- Latency is 1 cycle from `request` to `grant`:
  - `request[i]` rises before edge N while IDLE and i wins → `grant[i]` = 1 after edge N.
- Release latency is 1 cycle:
  - owner drops `request` before edge M → `grant` bit clears after edge M, and in the same cycle the next winner's bit is set if one exists.
- Preemption timing (maxHold = H):
  - The owner is granted at edge N.
  - The counter reaches H after edge N+H.
  - With a competitor pending, the grant moves at edge N+H+1.
  - The owner therefore holds for exactly H+1 cycles.
- Simultaneous events:
  - Release and new requests at the same edge: arbitration uses the `request` values sampled at that edge.
  - Reset asserted mid-ownership: forces IDLE at that edge. The first post-reset grant uses `ptr` = 0.
- `grant` never has more than one bit set in any cycle, and changes only at rising edges of `clk`.

## Test plan
- Reset (width = 4): drive `request` = 4'b1111 with reset high → `grant` = 0. Release reset → after the next edge, `grant` = 4'b0001 and `grantIndex` = 0.
- Round-robin rotation (width = 4): hold `request` = 4'b1111; owner drops and re-raises its request each cycle → successive grants 0001, 0010, 0100, 1000, 0001.
- Fixed mode (roundRobin = 0): same stimulus → grant returns to 0001 after every release.
- Lock hold: `request` = 4'b0001 then 4'b0011 for 10 cycles with maxHold = 0 → `grant` stays 0001 throughout. Drop `request[0]` → 0010 on the next edge, with no idle cycle.
- Preemption (maxHold = 3): `request` = 4'b0101 constant → 0001 held exactly 4 cycles, then 0100 for 4 cycles, then 0001. `request` = 4'b0001 alone → never drops.
- Reset mid-operation: owner 2 active with ptr = 3; assert reset for one edge while `request` = 4'b1100 → `grant` = 0. On the next edge → 0100, because `ptr` has been reset to 0.

Source files
------------

// File: rtl/round_robin_arbiter.sv
// Registered arbiter: one of `width` requesters owns the resource until release or hold-time preemption.
// Latency 1 cycle request->grant; grant is a pure register output, no backpressure beyond request lines.
module round_robin_arbiter #(
  parameter int width      = 4,
  parameter int roundRobin = 1,
  parameter int maxHold    = 0,
  parameter int holdWidth  = 8,
  parameter int indexWidth = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [width-1:0]      request,
  output logic [width-1:0]      grant,
  output logic                  grantValid,
  output logic [indexWidth-1:0] grantIndex
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [holdWidth-1:0] HOLD_MAX = holdWidth'(maxHold);

  state_t                  state, state_nxt;
  logic [indexWidth-1:0]   owner, owner_nxt;
  logic [indexWidth-1:0]   ptr, ptr_nxt;
  logic [holdWidth-1:0]    hold, hold_nxt;
  logic [width-1:0]        grant_nxt;
  logic [width-1:0]        owner_mask, others, cand;
  logic                    preempt, arbitrate, found;
  logic [indexWidth-1:0]   winner, jsel;
  int                      j;

  assign owner_mask = width'(1) << owner;
  assign others     = request & ~owner_mask;
  // Preemption only when someone else is actually waiting; otherwise the owner keeps the grant.
  assign preempt    = (maxHold != 0) && (state == OWNED) && (hold == HOLD_MAX) && (|others);
  assign arbitrate  = (state == IDLE) || ((request & owner_mask) == '0) || preempt;
  assign cand       = preempt ? others : request;
  assign grantIndex = owner;

  // First set candidate searching upward from ptr (or 0 in fixed mode) with wrap.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    j      = 0;
    jsel   = '0;
    for (int k = 0; k < width; k++) begin
      j = ((roundRobin != 0) ? int'(ptr) : 0) + k;
      if (j >= width) j = j - width;
      jsel = indexWidth'(j);
      if (!found && cand[jsel]) begin
        found  = 1'b1;
        winner = jsel;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    hold_nxt  = hold;
    grant_nxt = grant;
    if (arbitrate) begin
      if (found) begin
        state_nxt = OWNED;
        owner_nxt = winner;
        grant_nxt = width'(1) << winner;
        hold_nxt  = '0;
        if (roundRobin != 0)
          ptr_nxt = (winner == indexWidth'(width - 1)) ? '0 : winner + 1'b1;
      end else begin
        state_nxt = IDLE;
        owner_nxt = '0;
        grant_nxt = '0;
        hold_nxt  = '0;
      end
    end else if ((maxHold != 0) && (hold != HOLD_MAX)) begin
      hold_nxt = hold + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      ptr        <= '0;
      hold       <= '0;
      grant      <= '0;
      grantValid <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      ptr        <= ptr_nxt;
      hold       <= hold_nxt;
      grant      <= grant_nxt;
      grantValid <= |grant_nxt;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scoreboard bench: three arbiter configurations (round-robin, fixed, maxHold=3) driven by directed vectors.
module tb_round_robin_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_rr, req_fx, req_ph;
  logic [3:0] g_rr, g_fx, g_ph;
  logic       v_rr, v_fx, v_ph;
  logic [1:0] i_rr, i_fx, i_ph;

  round_robin_arbiter u_rr (
    .clk(clk), .reset(rst), .request(req_rr),
    .grant(g_rr), .grantValid(v_rr), .grantIndex(i_rr)
  );

  round_robin_arbiter #(.roundRobin(0)) u_fx (
    .clk(clk), .reset(rst), .request(req_fx),
    .grant(g_fx), .grantValid(v_fx), .grantIndex(i_fx)
  );

  round_robin_arbiter #(.maxHold(3)) u_ph (
    .clk(clk), .reset(rst), .request(req_ph),
    .grant(g_ph), .grantValid(v_ph), .grantIndex(i_ph)
  );

  typedef struct packed {
    logic [1:0] dut;
    logic [3:0] grant;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    passes = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < 4; k++)
      if (g[k]) r = 2'(k);
    return r;
  endfunction

  task automatic step(input logic [1:0] d, input logic r, input logic [3:0] rq,
                      input logic [3:0] g, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    case (d)
      2'd0:    req_rr = rq;
      2'd1:    req_fx = rq;
      default: req_ph = rq;
    endcase
    e.dut   = d;
    e.grant = g;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: one expected entry per cycle, compared just after the edge that produced it.
  initial begin
    exp_t       e;
    string      nm;
    logic [3:0] g;
    logic       v;
    logic [1:0] i;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        case (e.dut)
          2'd0:    begin g = g_rr; v = v_rr; i = i_rr; end
          2'd1:    begin g = g_fx; v = v_fx; i = i_fx; end
          default: begin g = g_ph; v = v_ph; i = i_ph; end
        endcase
        checks++;
        if (g === e.grant && v === (|e.grant) && i === idx_of(e.grant))
          passes++;
        else
          $display("FAIL %s: got grant=%b valid=%b index=%0d, expected grant=%b valid=%b index=%0d",
                   nm, g, v, i, e.grant, |e.grant, idx_of(e.grant));
      end
    end
  end

  initial begin
    rst    = 1'b1;
    req_rr = 4'b0000;
    req_fx = 4'b0000;
    req_ph = 4'b0000;

    // Round-robin: reset, rotation, lock hold, handover, reset mid-ownership
    step(2'd0, 1'b1, 4'b1111, 4'b0000, "rr_reset");
    step(2'd0, 1'b0, 4'b1111, 4'b0001, "rr_first_grant");
    step(2'd0, 1'b0, 4'b1110, 4'b0010, "rr_rot1");
    step(2'd0, 1'b0, 4'b1101, 4'b0100, "rr_rot2");
    step(2'd0, 1'b0, 4'b1011, 4'b1000, "rr_rot3");
    step(2'd0, 1'b0, 4'b0111, 4'b0001, "rr_rot_wrap");
    step(2'd0, 1'b0, 4'b0000, 4'b0000, "rr_idle");
    step(2'd0, 1'b0, 4'b0001, 4'b0001, "rr_lock_start");
    for (int k = 0; k < 10; k++)
      step(2'd0, 1'b0, 4'b0011, 4'b0001, "rr_lock_hold");
    step(2'd0, 1'b0, 4'b0010, 4'b0010, "rr_handover");
    step(2'd0, 1'b0, 4'b0100, 4'b0100, "rr_owner2");
    step(2'd0, 1'b1, 4'b1100, 4'b0000, "rr_mid_reset");
    step(2'd0, 1'b0, 4'b1100, 4'b0100, "rr_ptr_cleared");
    step(2'd0, 1'b0, 4'b0000, 4'b0000, "rr_release_all");

    // Fixed priority: lowest index wins after every release
    step(2'd1, 1'b0, 4'b1111, 4'b0001, "fx_first");
    step(2'd1, 1'b0, 4'b1110, 4'b0010, "fx_rel0");
    step(2'd1, 1'b0, 4'b1101, 4'b0001, "fx_back0_a");
    step(2'd1, 1'b0, 4'b1110, 4'b0010, "fx_rel0_b");
    step(2'd1, 1'b0, 4'b1101, 4'b0001, "fx_back0_b");
    step(2'd1, 1'b0, 4'b0000, 4'b0000, "fx_idle");
    step(2'd1, 1'b0, 4'b1100, 4'b0100, "fx_low_of_two");
    step(2'd1, 1'b0, 4'b1000, 4'b1000, "fx_handover3");
    step(2'd1, 1'b0, 4'b0000, 4'b0000, "fx_release");

    // Preemption with maxHold=3: each owner holds exactly 4 cycles
    for (int k = 0; k < 4; k++)
      step(2'd2, 1'b0, 4'b0101, 4'b0001, "ph_hold0");
    for (int k = 0; k < 4; k++)
      step(2'd2, 1'b0, 4'b0101, 4'b0100, "ph_hold2");
    step(2'd2, 1'b0, 4'b0101, 4'b0001, "ph_back0");
    for (int k = 0; k < 8; k++)
      step(2'd2, 1'b0, 4'b0001, 4'b0001, "ph_alone_kept");
    step(2'd2, 1'b0, 4'b0101, 4'b0100, "ph_saturated_preempt");
    step(2'd2, 1'b0, 4'b0000, 4'b0000, "ph_release");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++)
      @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
